// File: rtl/scan_pkg.sv
// Shared state encoding, code width and code-advance helper for the scan_seq38 sequencer.
package scan_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns {wrap, next_code}; stepping up past last or down past 0 wraps around.
    function automatic logic [CODE_W:0] adv_code(
        input logic [CODE_W-1:0] code,
        input logic [CODE_W-1:0] last,
        input logic              down
    );
        logic [CODE_W:0] w_res;
        if (down) begin
            w_res = (code == '0) ? {1'b1, last} : {1'b0, code - CODE_W'(1)};
        end else begin
            w_res = (code >= last) ? {1'b1, {CODE_W{1'b0}}} : {1'b0, code + CODE_W'(1)};
        end
        return w_res;
    endfunction

endpackage

// File: rtl/scan_seq38_dwell_cnt.sv
// Dwell counter: holds a shadow copy of the dwell value and counts 0..shadow while enabled.
module dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_clear,
    input  logic               i_en,
    output logic               o_tc
);

    logic [DWELL_W-1:0] r_shadow;
    logic [DWELL_W-1:0] r_cnt;

    assign o_tc = (r_cnt == r_shadow);

    // Load takes priority so a fresh start always begins its first hold from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_shadow <= i_dwell;
            r_cnt    <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/scan_seq38.sv
// 3-bit code scanner with dwell, single-step and wrap pulse.
// Optional macro SCAN_DOWN_EN adds a dir input for down-counting.
module scan_seq38
    import scan_pkg::*;
#(
    parameter int DWELL_W = 4,
    parameter int LAST    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_DOWN_EN
    input  logic               dir,
`endif
    output logic               x,
    output logic               y,
    output logic               z,
    output logic               busy,
    output logic               wrap,
    output state_t             o_dbg_state
);

    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(LAST);

    state_t            r_state;
    state_t            w_next_state;
    logic [CODE_W-1:0] r_code;
    logic              r_wrap;
    logic              w_load;
    logic              w_clear;
    logic              w_en;
    logic              w_tc;
    logic              w_advance;
    logic              w_down;
    logic [CODE_W:0]   w_adv;

`ifdef SCAN_DOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_dwell (dwell),
        .i_clear (w_clear),
        .i_en    (w_en),
        .o_tc    (w_tc)
    );

    assign w_adv = adv_code(r_code, LAST_CODE, w_down);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // start/stop/step are plain levels sampled every edge: stop beats start, start beats step.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_en         = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!stop && start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end else if (!start && step) begin
                    w_advance = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next_state = IDLE;
                    w_clear      = 1'b1;
                end else begin
                    w_en      = 1'b1;
                    w_advance = w_tc;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_advance & w_adv[CODE_W];
            if (w_advance) begin
                r_code <= w_adv[CODE_W-1:0];
            end
        end
    end

    assign {x, y, z}   = r_code;
    assign busy        = (r_state == RUN);
    assign wrap        = r_wrap;
    assign o_dbg_state = r_state;

endmodule

// File: doc/scan_seq38.md
SCAN_SEQ38 -- requirements
Module: scan_seq38

Interface
REQ-001 Parameter DWELL_W, default 4: width of the dwell input and the dwell counter.
REQ-002 Parameter LAST, default 7: highest code in the scan, range 1..7.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: level sampled each cycle; begins continuous scanning.
REQ-006 Port stop, input, 1: level sampled each cycle; ends scanning.
REQ-007 Port step, input, 1: single-step request, honoured only when idle.
REQ-008 Port dwell, input, DWELL_W: number of extra cycles each code is held; the hold time is dwell+1 cycles.
REQ-009 Ports x, y, z, output, 1 each: current 3-bit code {x,y,z}, with x as MSB; drives a 3-to-8 decoder directly.
REQ-010 Port busy, output, 1: high while in RUN.
REQ-011 Port wrap, output, 1: one-cycle pulse when the code wraps.

Function
REQ-012 FSM states SHALL be IDLE and RUN only.
REQ-013 IDLE -> RUN SHALL occur on start=1 with stop=0; dwell is latched into a shadow register on the same edge.
REQ-014 RUN -> IDLE SHALL occur on stop=1; the code holds its current value and the dwell counter clears.
REQ-015 If start and stop are both high in the same cycle, stop SHALL win in either state.
REQ-016 A start in RUN SHALL be ignored; the latched dwell is not re-sampled.
REQ-017 Dwell counter in RUN: counts 0..latched dwell. At terminal count the code advances by one and the counter returns to 0.
REQ-018 Hold time of each code in RUN:
- first code after start: exactly dwell+1 cycles, counted from the cycle busy rises;
- every later code: also dwell+1 cycles.
REQ-019 Advancing from code LAST SHALL load 0 and assert wrap for that one cycle. No code above LAST is ever output.
REQ-020 dwell=0 SHALL advance the code every cycle in RUN.
REQ-021 step=1 in IDLE SHALL advance the code by one on the next edge, with the same wrap rule; busy stays 0.
REQ-022 step in RUN SHALL be ignored. step and start high together in IDLE: start wins and step is discarded.
REQ-023 Outputs SHALL be registered: the code, busy and wrap change only on clk edges (or on reset).

Reset
REQ-024 rst_n=0 SHALL immediately force the following, regardless of clk:
- {x,y,z}=000, busy=0, wrap=0;
- FSM=IDLE;
- dwell counter=0, shadow dwell=0.
REQ-025 Reset asserted mid-scan SHALL abandon the scan. After release the block stays idle until a new start.
REQ-026 The first edge after rst_n rises SHALL act on inputs normally.

Configuration
REQ-027 Macro SCAN_DOWN_EN:
- Defined: adds input port dir (1 bit, 1 = count down). dir is sampled at every advance. Counting down from 0 loads LAST and pulses wrap. Counting up behaves as in REQ-019.
- Undefined: no dir port; the block always counts up.

Structure
REQ-028 The state encoding (IDLE, RUN) and the code width constant CODE_W=3 SHALL live in shared package scan_pkg.
REQ-029 One sub-module, dwell_cnt, SHALL provide the dwell counter: load/clear inputs and a terminal-count output. Everything else stays in scan_seq38.

Verification
REQ-030 Reset then start pulse with dwell=2 -> busy=1 next cycle; code sequence 0,0,0,1,1,1,2,... with each value held 3 cycles.
REQ-031 LAST=5, dwell=0, run -> codes 0,1,2,3,4,5,0 on successive cycles; wrap=1 only in the cycle code returns to 0.
REQ-032 IDLE with code=7, step pulse -> code=0 with wrap=1 for one cycle, busy stays 0. Step during RUN -> sequence unchanged.
REQ-033 start and stop high in the same cycle while IDLE -> remains IDLE. Stop while RUN at code 4 -> busy=0 next cycle, code holds 4.
REQ-034 rst_n asserted asynchronously mid-RUN at code 6 -> outputs 000, busy=0 before the next edge; no activity after release until start.
REQ-035 With SCAN_DOWN_EN, dir=1, dwell=0, starting at code 1 -> codes 1,0,LAST with wrap=1 on LAST.
